// File: rtl/stpm_pkg.sv
// -----------------------------------------------------------------------------
// stpm_pkg
// Shared definitions for the stepper-motor keypad command parser:
//   - keypad token encodings (digits 0-9 are their own value)
//   - command-parser FSM state encoding
//   - small token-classification helper
// -----------------------------------------------------------------------------
package stpm_pkg;

  localparam logic [3:0] TOK_SPACE    = 4'hA;
  localparam logic [3:0] TOK_ENTER    = 4'hB;
  localparam logic [3:0] TOK_FORWARD  = 4'hC;
  localparam logic [3:0] TOK_BACKWARD = 4'hD;
  localparam logic [3:0] TOK_INVALID  = 4'hE;

  // IDLE expects a motor digit, SEP a SPACE, DIR a direction, DIG1 the first
  // degree digit, DIGN further digits or ENTER.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEP  = 3'd1,
    ST_DIR  = 3'd2,
    ST_DIG1 = 3'd3,
    ST_DIGN = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [3:0] tok);
    return tok <= 4'd9;
  endfunction

endpackage

// File: rtl/stpm_deg2cyc.sv
// -----------------------------------------------------------------------------
// stpm_deg2cyc
// Purely combinational conversion of an angle in degrees to stepper cycles:
//   cycles = floor(deg * 5 / 9), exact over 0..999.
// Ports:
//   deg    in  10  angle in degrees
//   cycles out 10  step cycles (max 555 for deg = 999)
// -----------------------------------------------------------------------------
module stpm_deg2cyc (
  input  logic [9:0] deg,
  output logic [9:0] cycles
);

  // 999 * 5 = 4995 needs 13 bits before the division.
  logic [12:0] prod;

  assign prod   = {3'b000, deg} * 13'd5;
  assign cycles = 10'(prod / 13'd9);

endmodule

// File: rtl/stpm_cmd_parser.sv
// -----------------------------------------------------------------------------
// stpm_cmd_parser
// Parses keypad tokens of the form
//   <motor 1-4> SPACE <FORWARD|BACKWARD> <1-3 decimal digits> ENTER
// and loads a motor-select / direction / step-cycle command.
//
// Optional feature: define STPM_CMD_TIMEOUT_EN to abort a partial command
// after TIMEOUT_CYC clocks without a strobe. Without it a partial command
// waits indefinitely and no timeout counter exists.
//
// Ports:
//   i_Clk    in   1  clock, rising edge
//   i_Rst    in   1  asynchronous active-high reset
//   i_Data   in   4  keypad token (0-9, A SPACE, B ENTER, C FWD, D BWD, E INVALID)
//   i_Ena    in   1  token strobe
//   o_En     out  4  one-hot motor select (bit n-1 = motor n)
//   o_Dir    out  1  0 forward, 1 backward
//   o_Cycles out 10  step cycles for the stepper driver
//   o_Valid  out  1  one-cycle pulse: new command loaded
//   o_Err    out  1  one-cycle pulse: command rejected
//   o_Busy   out  1  a command is partially entered
// -----------------------------------------------------------------------------
module stpm_cmd_parser
  import stpm_pkg::*;
#(
  parameter int MAX_DEG     = 360,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Data,
  input  logic       i_Ena,
  output logic [3:0] o_En,
  output logic       o_Dir,
  output logic [9:0] o_Cycles,
  output logic       o_Valid,
  output logic       o_Err,
  output logic       o_Busy
);

  // Elaboration-time parameter sanity checks.
  if (MAX_DEG < 0 || MAX_DEG > 999) begin : g_bad_max_deg
    $error("MAX_DEG must lie in 0..999");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  localparam logic [9:0] MAX_DEG_W = 10'(MAX_DEG);

  state_t      state, state_d;
  logic [9:0]  deg, deg_d;
  logic [1:0]  ndig, ndig_d;     // digits entered so far (1..3 in DIGN)
  logic [1:0]  motor, motor_d;   // motor index 0..3
  logic        dir_sel, dir_sel_d;
  logic        load, reject;
  logic [13:0] deg_mac;
  logic [9:0]  cyc_conv;
  logic        timeout;

  stpm_deg2cyc u_deg2cyc (
    .deg    (deg),
    .cycles (cyc_conv)
  );

  assign deg_mac = {4'd0, deg} * 14'd10 + {10'd0, i_Data};

`ifdef STPM_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] idle_cnt;

  // Counts clocks since the last strobe while a command is in progress.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      idle_cnt <= '0;
    end else if (state == ST_IDLE || i_Ena) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYC-th strobe-free clock after the last strobe.
  assign timeout = (state != ST_IDLE) && !i_Ena &&
                   (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state;
    deg_d     = deg;
    ndig_d    = ndig;
    motor_d   = motor;
    dir_sel_d = dir_sel;
    load      = 1'b0;
    reject    = 1'b0;

    if (i_Ena) begin
      case (state)
        ST_IDLE: begin
          if (i_Data >= 4'd1 && i_Data <= 4'd4) begin
            motor_d = 2'(i_Data - 4'd1);
            state_d = ST_SEP;
          end else begin
            reject = 1'b1;
          end
        end
        ST_SEP: begin
          if (i_Data == TOK_SPACE) state_d = ST_DIR;
          else                     reject  = 1'b1;
        end
        ST_DIR: begin
          if (i_Data == TOK_FORWARD) begin
            dir_sel_d = 1'b0;
            state_d   = ST_DIG1;
          end else if (i_Data == TOK_BACKWARD) begin
            dir_sel_d = 1'b1;
            state_d   = ST_DIG1;
          end else begin
            reject = 1'b1;
          end
        end
        ST_DIG1: begin
          // ENTER here means no digits were given, which is rejected too.
          if (is_digit(i_Data)) begin
            deg_d   = {6'd0, i_Data};
            ndig_d  = 2'd1;
            state_d = ST_DIGN;
          end else begin
            reject = 1'b1;
          end
        end
        ST_DIGN: begin
          if (is_digit(i_Data)) begin
            if (ndig == 2'd3) begin
              reject = 1'b1;
            end else begin
              deg_d  = deg_mac[9:0];
              ndig_d = ndig + 2'd1;
            end
          end else if (i_Data == TOK_ENTER && deg <= MAX_DEG_W) begin
            load    = 1'b1;
            state_d = ST_IDLE;
            deg_d   = '0;
            ndig_d  = '0;
          end else begin
            reject = 1'b1;
          end
        end
        default: reject = 1'b1;
      endcase
    end else if (timeout) begin
      reject = 1'b1;
    end

    if (reject) begin
      state_d = ST_IDLE;
      deg_d   = '0;
      ndig_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state   <= ST_IDLE;
      deg     <= '0;
      ndig    <= '0;
      motor   <= '0;
      dir_sel <= 1'b0;
    end else begin
      state   <= state_d;
      deg     <= deg_d;
      ndig    <= ndig_d;
      motor   <= motor_d;
      dir_sel <= dir_sel_d;
    end
  end

  // Command outputs change only on a successful ENTER.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_En     <= '0;
      o_Dir    <= 1'b0;
      o_Cycles <= '0;
      o_Valid  <= 1'b0;
      o_Err    <= 1'b0;
    end else begin
      o_Valid <= load;
      o_Err   <= reject;
      if (load) begin
        o_En     <= 4'b0001 << motor;
        o_Dir    <= dir_sel;
        o_Cycles <= cyc_conv;
      end
    end
  end

  assign o_Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_stpm_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_stpm_cmd_parser
// Directed self-checking bench for stpm_cmd_parser. Tokens are driven on the
// falling edge and outputs are sampled 1 time unit after the rising edge on
// which the token is taken. Consecutive send() calls strobe on consecutive
// cycles.
// -----------------------------------------------------------------------------
module tb_stpm_cmd_parser;
  import stpm_pkg::*;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic [3:0] i_Data;
  logic       i_Ena;
  logic [3:0] o_En;
  logic       o_Dir;
  logic [9:0] o_Cycles;
  logic       o_Valid;
  logic       o_Err;
  logic       o_Busy;

  int checks = 0;
  int errors = 0;

  always #5 i_Clk = ~i_Clk;

`ifdef STPM_CMD_TIMEOUT_EN
  stpm_cmd_parser #(.MAX_DEG(360), .TIMEOUT_CYC(20)) dut (
`else
  stpm_cmd_parser #(.MAX_DEG(360)) dut (
`endif
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Data   (i_Data),
    .i_Ena    (i_Ena),
    .o_En     (o_En),
    .o_Dir    (o_Dir),
    .o_Cycles (o_Cycles),
    .o_Valid  (o_Valid),
    .o_Err    (o_Err),
    .o_Busy   (o_Busy)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Strobe one token; returns 1 unit after the edge that takes it.
  task automatic send(input logic [3:0] tok);
    @(negedge i_Clk);
    i_Data = tok;
    i_Ena  = 1'b1;
    @(posedge i_Clk);
    #1;
    i_Ena  = 1'b0;
  endtask

  task automatic send_seq(input logic [3:0] toks[$]);
    foreach (toks[i]) send(toks[i]);
  endtask

  task automatic check_cmd(input string tag, input logic [3:0] en,
                           input logic dir, input logic [9:0] cyc);
    check({tag, "_en"},  32'(o_En),     32'(en));
    check({tag, "_dir"}, 32'(o_Dir),    32'(dir));
    check({tag, "_cyc"}, 32'(o_Cycles), 32'(cyc));
  endtask

  // o_Valid and o_Err must never be high together.
  always @(negedge i_Clk) begin
    if (!i_Rst) check("valid_err_excl", 32'(o_Valid & o_Err), 32'd0);
  end

  initial begin
    #200_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_Rst  = 1'b1;
    i_Data = 4'd0;
    i_Ena  = 1'b0;
    repeat (2) @(posedge i_Clk);
    #1;
    check_cmd("rst", 4'b0000, 1'b0, 10'd0);
    check("rst_valid", 32'(o_Valid), 32'd0);
    check("rst_err",   32'(o_Err),   32'd0);
    check("rst_busy",  32'(o_Busy),  32'd0);
    @(negedge i_Clk);
    i_Rst = 1'b0;

    // Motor 2, forward, 128 deg -> 71 cycles.
    send_seq('{4'd2, TOK_SPACE, TOK_FORWARD, 4'd1, 4'd2, 4'd8});
    check("c1_busy", 32'(o_Busy), 32'd1);
    check("c1_valid_early", 32'(o_Valid), 32'd0);
    send(TOK_ENTER);
    check("c1_valid", 32'(o_Valid), 32'd1);
    check("c1_err",   32'(o_Err),   32'd0);
    check("c1_busy_after", 32'(o_Busy), 32'd0);
    check_cmd("c1", 4'b0010, 1'b0, 10'd71);
    @(posedge i_Clk); #1;
    check("c1_valid_pulse", 32'(o_Valid), 32'd0);
    check_cmd("c1_hold", 4'b0010, 1'b0, 10'd71);

    // Motor 1 backward 87 -> 48, then motor 3 backward 210 -> 116.
    send_seq('{4'd1, TOK_SPACE, TOK_BACKWARD, 4'd8, 4'd7, TOK_ENTER});
    check("c2_valid", 32'(o_Valid), 32'd1);
    check_cmd("c2", 4'b0001, 1'b1, 10'd48);
    send_seq('{4'd3, TOK_SPACE, TOK_BACKWARD, 4'd2, 4'd1, 4'd0, TOK_ENTER});
    check("c3_valid", 32'(o_Valid), 32'd1);
    check_cmd("c3", 4'b0100, 1'b1, 10'd116);

    // 400 > MAX_DEG: rejected, outputs kept; then 7 deg -> 3 cycles.
    send_seq('{4'd4, TOK_SPACE, TOK_FORWARD, 4'd4, 4'd0, 4'd0, TOK_ENTER});
    check("c4_err",   32'(o_Err),   32'd1);
    check("c4_valid", 32'(o_Valid), 32'd0);
    check_cmd("c4_keep", 4'b0100, 1'b1, 10'd116);
    @(posedge i_Clk); #1;
    check("c4_err_pulse", 32'(o_Err), 32'd0);
    send_seq('{4'd4, TOK_SPACE, TOK_FORWARD, 4'd7, TOK_ENTER});
    check("c5_valid", 32'(o_Valid), 32'd1);
    check_cmd("c5", 4'b1000, 1'b0, 10'd3);

    // Motor digit 5 as first token.
    send(4'd5);
    check("bad_motor_err",  32'(o_Err),  32'd1);
    check("bad_motor_busy", 32'(o_Busy), 32'd0);

    // Fourth digit.
    send_seq('{4'd1, TOK_SPACE, TOK_FORWARD, 4'd1, 4'd2, 4'd3});
    check("dig4_busy_before", 32'(o_Busy), 32'd1);
    send(4'd4);
    check("dig4_err",  32'(o_Err),  32'd1);
    check("dig4_busy", 32'(o_Busy), 32'd0);
    check_cmd("dig4_keep", 4'b1000, 1'b0, 10'd3);

    // Tokens without strobe are ignored.
    @(negedge i_Clk);
    i_Data = 4'd2;
    repeat (3) @(posedge i_Clk);
    #1;
    check("noena_busy", 32'(o_Busy), 32'd0);
    check("noena_err",  32'(o_Err),  32'd0);

    // ENTER with no digits, wrong class, INVALID token.
    send_seq('{4'd2, TOK_SPACE, TOK_FORWARD, TOK_ENTER});
    check("nodig_err", 32'(o_Err), 32'd1);
    send_seq('{4'd2, TOK_FORWARD});
    check("class_err", 32'(o_Err), 32'd1);
    send_seq('{4'd2, TOK_SPACE, TOK_INVALID});
    check("inval_err", 32'(o_Err), 32'd1);
    send(4'hF);
    check("tokf_err", 32'(o_Err), 32'd1);
    send(4'd0);
    check("motor0_err", 32'(o_Err), 32'd1);

    // deg = 0 is valid.
    send_seq('{4'd2, TOK_SPACE, TOK_BACKWARD, 4'd0, TOK_ENTER});
    check("zero_valid", 32'(o_Valid), 32'd1);
    check_cmd("zero", 4'b0010, 1'b1, 10'd0);

    // MAX_DEG boundary: 360 -> 200 accepted, 361 rejected.
    send_seq('{4'd1, TOK_SPACE, TOK_FORWARD, 4'd3, 4'd6, 4'd0, TOK_ENTER});
    check("max_valid", 32'(o_Valid), 32'd1);
    check_cmd("max", 4'b0001, 1'b0, 10'd200);
    send_seq('{4'd2, TOK_SPACE, TOK_BACKWARD, 4'd3, 4'd6, 4'd1, TOK_ENTER});
    check("over_err", 32'(o_Err), 32'd1);
    check_cmd("over_keep", 4'b0001, 1'b0, 10'd200);

    // Reset mid-command.
    send_seq('{4'd1, TOK_SPACE, TOK_FORWARD});
    check("mid_busy", 32'(o_Busy), 32'd1);
    @(negedge i_Clk);
    i_Rst = 1'b1;
    #1;
    check_cmd("mid_rst", 4'b0000, 1'b0, 10'd0);
    check("mid_rst_busy",  32'(o_Busy),  32'd0);
    check("mid_rst_valid", 32'(o_Valid), 32'd0);
    check("mid_rst_err",   32'(o_Err),   32'd0);
    @(negedge i_Clk);
    i_Rst = 1'b0;
    send_seq('{4'd3, TOK_SPACE, TOK_FORWARD, 4'd9, TOK_ENTER});
    check("post_rst_valid", 32'(o_Valid), 32'd1);
    check_cmd("post_rst", 4'b0100, 1'b0, 10'd5);

`ifdef STPM_CMD_TIMEOUT_EN
    // Abort 20 clocks after the SPACE strobe.
    send_seq('{4'd1, TOK_SPACE});
    repeat (19) @(posedge i_Clk);
    #1;
    check("to_err_early",  32'(o_Err),  32'd0);
    check("to_busy_early", 32'(o_Busy), 32'd1);
    @(posedge i_Clk); #1;
    check("to_err",  32'(o_Err),  32'd1);
    check("to_busy", 32'(o_Busy), 32'd0);
    check_cmd("to_keep", 4'b0100, 1'b0, 10'd5);
`else
    // Without the timeout a partial command waits indefinitely.
    send_seq('{4'd1, TOK_SPACE, TOK_FORWARD});
    repeat (40) @(posedge i_Clk);
    #1;
    check("wait_err",  32'(o_Err),  32'd0);
    check("wait_busy", 32'(o_Busy), 32'd1);
    send_seq('{4'd5, TOK_ENTER});
    check("wait_valid", 32'(o_Valid), 32'd1);
    check_cmd("wait", 4'b0001, 1'b0, 10'd2);
`endif

    repeat (2) @(posedge i_Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stpm_cmd_parser.md
STPM_CMD_PARSER -- requirements
Module: stpm_cmd_parser

Interface
REQ-001 SHALL have parameter MAX_DEG, default 360, the largest accepted angle in degrees.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1_000_000, the idle-token abort limit in clocks (used only with the timeout feature).
REQ-003 SHALL have port i_Clk  input  1  the single clock; all flops on the rising edge.
REQ-004 SHALL have port i_Rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_Data  input  4  keypad token: 0-9 digit, 0xA SPACE, 0xB ENTER, 0xC FORWARD, 0xD BACKWARD, 0xE INVALID.
REQ-006 SHALL have port i_Ena  input  1  one-cycle strobe; i_Data is sampled only when it is high.
REQ-007 SHALL have port o_En  output  4  one-hot motor select, active-high; bit n-1 selects motor n.
REQ-008 SHALL have port o_Dir  output  1  0 = forward, 1 = backward.
REQ-009 SHALL have port o_Cycles  output  10  step cycles for the downstream stepper driver.
REQ-010 SHALL have port o_Valid  output  1  one-cycle pulse when a new command is loaded.
REQ-011 SHALL have port o_Err  output  1  one-cycle pulse when a command is rejected.
REQ-012 SHALL have port o_Busy  output  1  high while a command is partially entered (state != IDLE).

Function
REQ-013 SHALL accept the grammar: motor digit 1-4, SPACE, FORWARD or BACKWARD, 1-3 decimal digits, ENTER.
REQ-014 SHALL implement the FSM states IDLE->SEP->DIR->DIG1->DIGN->IDLE; each transition occurs only on a strobed token that matches the expected class.
REQ-015 SHALL accumulate degrees as deg = deg*10 + digit, held in 10 bits.
REQ-016 SHALL compute cycles as floor(deg*5/9), exact for deg 0-999.
REQ-017 SHALL, on ENTER in DIGN with deg <= MAX_DEG, register o_En, o_Dir and o_Cycles and pulse o_Valid in the cycle after the ENTER strobe.
REQ-018 SHALL hold o_En, o_Dir and o_Cycles stable until the next valid command or reset.
REQ-019 SHALL treat any of the following as an error: an unexpected token class, motor digit 0 or 5-9, a 4th digit, ENTER with no digits, deg > MAX_DEG, or the INVALID/0xF token.
REQ-020 SHALL, on error, pulse o_Err in the cycle after the offending strobe, clear the accumulator, return to IDLE, and leave the previous outputs unchanged.
REQ-021 SHALL accept deg = 0 as a valid command and output o_Cycles = 0.
REQ-022 SHALL ignore tokens while i_Ena is low; back-to-back strobes on consecutive cycles SHALL each be processed.
REQ-023 SHALL never assert o_Valid and o_Err in the same cycle.

Reset
REQ-024 SHALL, on i_Rst high at any time including mid-command, immediately set: state = IDLE, accumulator = 0, o_En = 0000, o_Dir = 0, o_Cycles = 0, o_Valid = 0, o_Err = 0, o_Busy = 0.

Configuration
REQ-025 SHALL, with macro STPM_CMD_TIMEOUT_EN defined, abort a partial command after TIMEOUT_CYC clocks without a strobe: pulse o_Err, clear the accumulator and return to IDLE.
REQ-026 SHALL, without STPM_CMD_TIMEOUT_EN defined, omit the timeout counter entirely, so a partial command waits indefinitely.

Structure
REQ-027 SHALL place the token localparams (SPACE, ENTER, FORWARD, BACKWARD, INVALID) and the FSM state enum in shared package stpm_pkg.
REQ-028 SHALL implement the degree-to-cycles conversion in sub-module stpm_deg2cyc (10-bit in, 10-bit out, purely combinational).

Verification
REQ-029 SHALL cover: tokens 2, SPACE, FORWARD, 1, 2, 8, ENTER -> one o_Valid pulse with o_En = 0010, o_Dir = 0, o_Cycles = 71.
REQ-030 SHALL cover: tokens 1, SPACE, BACKWARD, 8, 7, ENTER, then 3, SPACE, BACKWARD, 2, 1, 0, ENTER -> o_Cycles = 48 then 116, o_Dir = 1, o_En = 0001 then 0100.
REQ-031 SHALL cover: tokens 4, SPACE, FORWARD, 4, 0, 0, ENTER -> o_Err pulse, outputs unchanged; then 4, SPACE, FORWARD, 7, ENTER -> o_Cycles = 3, o_En = 1000.
REQ-032 SHALL cover: token 5 as first token, and separately four digits -> o_Err pulse each time and o_Busy = 0 afterwards.
REQ-033 SHALL cover: i_Rst asserted after 1, SPACE, FORWARD -> all outputs 0 and a following full command accepted normally.
REQ-034 SHALL cover, with STPM_CMD_TIMEOUT_EN and TIMEOUT_CYC = 20: tokens 1, SPACE, then no strobe -> o_Err pulse 20 clocks after the SPACE strobe.
